// File: rtl/stack_pkg.sv
// Shared definitions for the parameterised LIFO stack.
package stack_pkg;

   // One decoded operation per cycle; errors are tracked separately.
   typedef enum logic [1:0] {
      OP_NOP     = 2'd0,
      OP_PUSH    = 2'd1,
      OP_POP     = 2'd2,
      OP_REPLACE = 2'd3
   } stack_op_e;

   // Occupancy counter width: must represent 0..depth inclusive.
   function automatic int unsigned stack_cw(input int unsigned depth);
      return $clog2(depth + 1);
   endfunction

   // Storage address width: must represent 0..depth-1.
   function automatic int unsigned stack_aw(input int unsigned depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/stack_ram.sv
// Stack storage: one synchronous write port, one asynchronous read port, no reset.
module stack_ram
   import stack_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 8,
   localparam int unsigned AW   = stack_aw(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   // Synchronous write; contents are intentionally left unreset.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // Asynchronous read, guarded for non-power-of-two depths.
   always_comb begin
      rdata = '0;
      if (32'(raddr) < DEPTH) begin
         rdata = mem[raddr];
      end
   end

endmodule

// File: rtl/param_stack.sv
// Parameterised LIFO stack with peek, status flags and sticky error flags.
module param_stack
   import stack_pkg::*;
#(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned DEPTH     = 8,
   parameter int unsigned AFULL_LVL = DEPTH - 2,
   localparam int unsigned CW       = stack_cw(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic             clr_err,
   input  logic [WIDTH-1:0] data_in,
   output logic [WIDTH-1:0] data_out,
   output logic             data_valid,
   output logic [WIDTH-1:0] top,
   output logic [CW-1:0]    count,
   output logic             full,
   output logic             empty,
   output logic             almost_full,
   output logic             overflow,
   output logic             underflow
);

   localparam int unsigned AW = stack_aw(DEPTH);

   stack_op_e        op;
   logic             ovf_err;
   logic             udf_err;
   logic [CW-1:0]    count_d;
   logic [WIDTH-1:0] data_out_d;
   logic             data_valid_d;
   logic             we;
   logic [AW-1:0]    waddr;
   logic [AW-1:0]    top_idx;
   logic [WIDTH-1:0] rdata;

   // Status flags derived directly from occupancy.
   always_comb begin
      full        = (32'(count) == DEPTH);
      empty       = (count == '0);
      almost_full = (32'(count) >= AFULL_LVL);
      top_idx     = AW'(count - CW'(1));
      top         = empty ? '0 : rdata;
   end

   // Decode requests into a single operation plus error events.
   always_comb begin
      op      = OP_NOP;
      ovf_err = 1'b0;
      udf_err = 1'b0;
      if (push && pop) begin
         if (empty) begin
            op      = OP_PUSH;
            udf_err = 1'b1;
         end else begin
            op = OP_REPLACE;
         end
      end else if (push) begin
         if (full) ovf_err = 1'b1;
         else      op      = OP_PUSH;
      end else if (pop) begin
         if (empty) udf_err = 1'b1;
         else       op      = OP_POP;
      end
   end

   // Next-state and write-port control, all driven from one case on op.
   always_comb begin
      count_d      = count;
      data_out_d   = data_out;
      data_valid_d = 1'b0;
      we           = 1'b0;
      waddr        = AW'(count);
      case (op)
         OP_PUSH: begin
            we      = 1'b1;
            waddr   = AW'(count);
            count_d = count + CW'(1);
         end
         OP_POP: begin
            data_out_d   = rdata;
            data_valid_d = 1'b1;
            count_d      = count - CW'(1);
         end
         OP_REPLACE: begin
            data_out_d   = rdata;
            data_valid_d = 1'b1;
            we           = 1'b1;
            waddr        = top_idx;
         end
         default: ;
      endcase
   end

   // State registers; errors are sticky and win over a coincident clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count      <= '0;
         data_out   <= '0;
         data_valid <= 1'b0;
         overflow   <= 1'b0;
         underflow  <= 1'b0;
      end else begin
         count      <= count_d;
         data_out   <= data_out_d;
         data_valid <= data_valid_d;
         overflow   <= ovf_err | (overflow  & ~clr_err);
         underflow  <= udf_err | (underflow & ~clr_err);
      end
   end

   stack_ram #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_ram (
      .clk   (clk),
      .we    (we),
      .waddr (waddr),
      .wdata (data_in),
      .raddr (top_idx),
      .rdata (rdata)
   );

endmodule

// File: doc/param_stack.md
PARAM_STACK -- requirements
Module: param_stack

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data word width in bits (>=1).
REQ-002 SHALL have parameter DEPTH, default 8, number of entries (>=2, any integer, not restricted to powers of two).
REQ-003 SHALL have parameter AFULL_LVL, default DEPTH-2, count at or above which almost_full asserts.
REQ-004 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port push  input  1  push request.
REQ-007 SHALL have port pop  input  1  pop request.
REQ-008 SHALL have port clr_err  input  1  clears sticky error flags.
REQ-009 SHALL have port data_in  input  WIDTH  word to push.
REQ-010 SHALL have port data_out  output  WIDTH  last popped word, registered.
REQ-011 SHALL have port data_valid  output  1  one-cycle strobe marking a new data_out.
REQ-012 SHALL have port top  output  WIDTH  current top entry (peek), combinational.
REQ-013 SHALL have port count  output  CW=$clog2(DEPTH+1)  current occupancy.
REQ-014 SHALL have ports full, empty, almost_full  output  1 each  status.
REQ-015 SHALL have ports overflow, underflow  output  1 each  sticky error flags.

Function
REQ-016 SHALL derive full=(count==DEPTH), empty=(count==0), almost_full=(count>=AFULL_LVL) combinationally from count, valid in the same cycle count changes.
REQ-017 SHALL, on push only and not full, write data_in to entry count and increment count by 1.
REQ-018 SHALL, on pop only and not empty, register entry count-1 into data_out, pulse data_valid for one cycle, and decrement count by 1.
REQ-019 SHALL, on push and pop together and not empty (including full), perform replace: data_out<=old top, data_valid=1, entry count-1<=data_in, count unchanged.
REQ-020 SHALL, on push and pop together when empty, perform the push per REQ-017 and set underflow.
REQ-021 SHALL, on push only when full, discard data_in, leave count and memory unchanged, and set overflow.
REQ-022 SHALL, on pop only when empty, leave data_out unchanged, keep data_valid=0, and set underflow.
REQ-023 SHALL hold data_out between pops; data_valid SHALL be 0 on every cycle without a successful pop/replace.
REQ-024 SHALL drive top=entry count-1 when not empty, else all-zero.
REQ-025 SHALL keep overflow/underflow set until clr_err; if clr_err and a new error coincide, the flag SHALL be set.
REQ-026 SHALL never let count exceed DEPTH or wrap below 0.

Reset
REQ-027 SHALL, while rst=1, force count=0, data_out=0, data_valid=0, overflow=0, underflow=0, giving empty=1, full=0, top=0.
REQ-028 SHALL NOT reset storage contents; entries are undefined until written.
REQ-029 SHALL abandon any operation in progress when rst asserts mid-cycle; first legal operation is on the first rising edge after rst deasserts.

Structure
REQ-030 SHALL place the operation encoding (NOP, PUSH, POP, REPLACE) and the CW width helper in shared package stack_pkg.
REQ-031 SHALL decode push/pop/full/empty into one stack_pkg operation per cycle, with a single case on it driving all updates.
REQ-032 SHALL implement storage as sub-module stack_ram: DEPTH x WIDTH, one synchronous write port, one asynchronous read port.

Verification (WIDTH=8, DEPTH=4, AFULL_LVL=3)
REQ-033 SHALL cover push 0x11,0x22,0x33,0x44 -> count 1..4, almost_full at count 3, full at 4, top=0x44; push 0x55 -> overflow=1, count=4, top=0x44.
REQ-034 SHALL cover four pops from full -> data_out 0x44,0x33,0x22,0x11, each with one-cycle data_valid; empty=1 after the last; fifth pop -> underflow=1, data_out stays 0x11, data_valid=0.
REQ-035 SHALL cover replace at full (push+pop, data_in=0xAA) -> data_out=0x44, data_valid=1, count=4, top=0xAA, no overflow.
REQ-036 SHALL cover push+pop when empty with data_in=0x5A -> count=1, top=0x5A, underflow=1, data_valid=0.
REQ-037 SHALL cover clr_err with both flags set -> both 0 next cycle; clr_err coinciding with a pop on empty -> underflow stays 1.
REQ-038 SHALL cover rst asserted asynchronously mid-sequence with count=2 -> count=0, empty=1, data_valid=0, flags 0 before the next clock edge.
